// File: rtl/vga_led_decoder.sv
// -----------------------------------------------------------------------------
// vga_led_decoder
//
// Receive-side checker for the seven-segment VGA display generator. Watches the
// VGA stream in the 50 MHz domain, recovers the eight segment bytes from the
// rendered pixels and validates frame geometry before committing them.
//
// Optional build macro: VGA_LED_DECODER_MAJORITY_EN
//   defined   : each segment is a 2-of-3 vote over x-1, x, x+1 on its sample row
//   undefined : single centre-pixel sample
//
// Ports
//   clk50        in   system clock (50 MHz)
//   reset_n      in   asynchronous active-low reset
//   vga_clk      in   pixel clock, data valid at its rising edge
//   vga_hs       in   horizontal sync (not needed for decoding)
//   vga_vs       in   vertical sync, active low; its falling edge ends a frame
//   vga_blank_n  in   high during active video
//   vga_r/g/b    in   pixel colour, 8 bits each (blue is not used)
//   hex0..hex7   out  recovered segments {h,g,f,e,d,c,b,a}, bit0 = a
//   frame_done   out  one-cycle pulse, frame committed to hex0..hex7
//   frame_err    out  one-cycle pulse, frame rejected
//   locked       out  LOCK_FRAMES consecutive good frames seen
//   dbg_state    out  FSM state (0 = SEARCH, 1 = FRAME)
// -----------------------------------------------------------------------------
module vga_led_decoder #(
    parameter logic [7:0] THRESH      = 8'h80,
    parameter int         ACTIVE_W    = 640,
    parameter int         ACTIVE_H    = 480,
    parameter int         LOCK_FRAMES = 2
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       vga_clk,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       vga_blank_n,
    input  logic [7:0] vga_r,
    input  logic [7:0] vga_g,
    input  logic [7:0] vga_b,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic [7:0] hex4,
    output logic [7:0] hex5,
    output logic [7:0] hex6,
    output logic [7:0] hex7,
    output logic       frame_done,
    output logic       frame_err,
    output logic       locked,
    output logic       dbg_state
);
    localparam int            GW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0]    W_EXP  = 10'(ACTIVE_W);
    localparam logic [8:0]    H_EXP  = 9'(ACTIVE_H);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_FRAMES);

    // Segment sample cells (8x8 grid inside a 64x128 digit), index = bit.
    localparam logic [2:0] SEG_CX [8] = '{3'd2, 3'd5, 3'd5, 3'd2, 3'd0, 3'd0, 3'd2, 3'd6};
    localparam logic [3:0] SEG_CY [8] = '{4'd0, 4'd3, 4'd9, 4'd12, 4'd9, 4'd3, 4'd6, 4'd14};

`ifdef VGA_LED_DECODER_MAJORITY_EN
    // Vote is resolved one pixel late, once x+1 has arrived.
    localparam logic [2:0] X_FINE = 3'd5;
`else
    localparam logic [2:0] X_FINE = 3'd4;
`endif

    typedef enum logic {ST_SEARCH = 1'b0, ST_FRAME = 1'b1} state_t;

    // Input registers
    logic       r_vclk, r_vclk_d, r_vs, r_vs_d, r_blank_n;
    logic [7:0] r_r, r_g;

    // Decoder state
    state_t          r_state;
    logic            r_bl_s;          // blank_n seen at the previous strobe
    logic [9:0]      r_px;
    logic [8:0]      r_ln;
    logic            r_line_bad;
    logic [7:0][7:0] r_shadow;
    logic [7:0][7:0] r_hex;
    logic [GW-1:0]   r_good_cnt;
    logic            r_locked, r_done_pend, r_frame_done, r_frame_err;

    logic       w_stb, w_line_end, w_vs_fall, w_lit, w_sample;
    logic       w_in_digit, w_bad_next, w_good;
    logic [8:0] w_ln_next;
    logic [3:0] w_dcol;
    logic [2:0] w_digit;
    logic [GW-1:0] w_cnt_inc;
    logic       w_unused;

    assign w_unused = ^{vga_b, vga_hs};

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_vclk    <= 1'b0;
            r_vclk_d  <= 1'b0;
            r_vs      <= 1'b0;
            r_vs_d    <= 1'b0;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
        end else begin
            r_vclk    <= vga_clk;
            r_vclk_d  <= r_vclk;
            r_vs      <= vga_vs;
            r_vs_d    <= r_vs;
            r_blank_n <= vga_blank_n;
            r_r       <= vga_r;
            r_g       <= vga_g;
        end
    end

    assign w_stb      = r_vclk & ~r_vclk_d;
    // Line end is judged on pixel strobes so px still holds the full line count.
    assign w_line_end = w_stb & r_bl_s & ~r_blank_n;
    assign w_vs_fall  = r_vs_d & ~r_vs;
    assign w_lit      = (r_r >= THRESH) && (r_g < THRESH);

    // Line end is folded in before the frame decision so a coincident
    // blank fall and vs fall judge the completed line count.
    assign w_ln_next  = (w_line_end && (r_ln != 9'h1FF)) ? r_ln + 9'd1 : r_ln;
    assign w_bad_next = r_line_bad | (w_line_end & (r_px != W_EXP));
    assign w_good     = (w_ln_next == H_EXP) && !w_bad_next;

    assign w_dcol     = r_px[9:6];
    assign w_in_digit = (w_dcol >= 4'd1) && (w_dcol <= 4'd8) && (r_ln[8:7] == 2'b01);
    assign w_digit    = 3'(w_dcol - 4'd1);
    assign w_cnt_inc  = (r_good_cnt == LOCK_V) ? r_good_cnt : r_good_cnt + GW'(1);

`ifdef VGA_LED_DECODER_MAJORITY_EN
    logic r_lit_d1, r_lit_d2;   // lit of pixels x and x-1 when x+1 is current

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_lit_d1 <= 1'b0;
            r_lit_d2 <= 1'b0;
        end else if (w_stb && r_blank_n) begin
            r_lit_d1 <= w_lit;
            r_lit_d2 <= r_lit_d1;
        end
    end

    assign w_sample = (r_lit_d1 & r_lit_d2) | (r_lit_d1 & w_lit) | (r_lit_d2 & w_lit);
`else
    assign w_sample = w_lit;
`endif

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_SEARCH;
            r_bl_s       <= 1'b0;
            r_px         <= '0;
            r_ln         <= '0;
            r_line_bad   <= 1'b0;
            r_shadow     <= '0;
            r_hex        <= '0;
            r_good_cnt   <= '0;
            r_locked     <= 1'b0;
            r_done_pend  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= r_done_pend;
            r_done_pend  <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_stb) begin
                r_bl_s <= r_blank_n;
                if (r_blank_n) begin
                    if (r_px != 10'h3FF) begin
                        r_px <= r_px + 10'd1;
                    end
                    if ((r_state == ST_FRAME) && w_in_digit) begin
                        for (int s = 0; s < 8; s++) begin
                            if ((r_px[5:0] == {SEG_CX[s], X_FINE}) &&
                                (r_ln[6:0] == {SEG_CY[s], 3'd4})) begin
                                r_shadow[w_digit][s] <= w_sample;
                            end
                        end
                    end
                end else if (w_line_end) begin
                    r_px <= '0;
                end
            end

            r_ln       <= w_ln_next;
            r_line_bad <= w_bad_next;

            if (w_vs_fall) begin
                r_ln       <= '0;
                r_line_bad <= 1'b0;
                r_shadow   <= '0;
                r_state    <= ST_FRAME;
                if (r_state == ST_FRAME) begin
                    if (w_good) begin
                        r_hex       <= r_shadow;
                        r_done_pend <= 1'b1;
                        r_good_cnt  <= w_cnt_inc;
                        r_locked    <= (w_cnt_inc == LOCK_V);
                    end else begin
                        r_frame_err <= 1'b1;
                        r_good_cnt  <= '0;
                        r_locked    <= 1'b0;
                    end
                end
            end
        end
    end

    assign hex0       = r_hex[0];
    assign hex1       = r_hex[1];
    assign hex2       = r_hex[2];
    assign hex3       = r_hex[3];
    assign hex4       = r_hex[4];
    assign hex5       = r_hex[5];
    assign hex6       = r_hex[6];
    assign hex7       = r_hex[7];
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign locked     = r_locked;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_vga_led_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_led_decoder
//
// Renders seven-segment frames onto a VGA-style stream and checks the decoded
// bytes, frame pulses and lock against a frame-level model. The active area is
// narrowed to 192x248 through the parameters so that digits 0 and 1 and all
// sample rows are still fully rendered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_led_decoder;
    localparam int W    = 192;
    localparam int H    = 248;
    localparam int LOCK = 2;

    // ---------------- clock / reset ----------------
    logic clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    logic       reset_n, vga_clk, vga_hs, vga_vs, vga_blank_n;
    logic [7:0] vga_r, vga_g, vga_b;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic       frame_done, frame_err, locked, dbg_state;

    vga_led_decoder #(
        .THRESH(8'h80), .ACTIVE_W(W), .ACTIVE_H(H), .LOCK_FRAMES(LOCK)
    ) dut (
        .clk50(clk50), .reset_n(reset_n), .vga_clk(vga_clk), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .frame_done(frame_done), .frame_err(frame_err), .locked(locked),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_done = 0;
    int cnt_err = 0;
    int cnt_both = 0;

    logic [7:0] pat [8];
    logic [7:0] exp_hex [8];
    logic [7:0] exp_q [$];
    int         m_good = 0;
    bit         m_search = 1'b1;
    bit         cur_glitch = 1'b0;

    int seg_cx [8] = '{2, 5, 5, 2, 0, 0, 2, 6};
    int seg_cy [8] = '{0, 3, 9, 12, 9, 3, 6, 14};

    always @(negedge clk50) begin
        if (frame_done) cnt_done <= cnt_done + 1;
        if (frame_err) cnt_err <= cnt_err + 1;
        if (frame_done && frame_err) cnt_both <= cnt_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_hex(input int k);
        case (k)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            3: return hex3;
            4: return hex4;
            5: return hex5;
            6: return hex6;
            default: return hex7;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pix(input logic bl, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vga_blank_n = bl;
        vga_r = r;
        vga_g = g;
        vga_b = b;
        vga_clk = 1'b0;
        @(negedge clk50);
        vga_clk = 1'b1;
        @(negedge clk50);
    endtask

    task automatic draw_px(input int x, input int y, input int mode, input bit glitch);
        int k;
        int cx;
        int cy;
        bit in_seg;
        bit lit;
        logic [7:0] r, g, b;
        in_seg = 1'b0;
        lit = 1'b0;
        k = x / 64 - 1;
        if (k >= 0 && k < 8 && y >= 128 && y < 256) begin
            cx = (x % 64) / 8;
            cy = (y - 128) / 8;
            for (int i = 0; i < 8; i++) begin
                if (seg_cx[i] == cx && seg_cy[i] == cy) begin
                    in_seg = 1'b1;
                    lit = pat[k][i];
                end
            end
        end
        if (glitch && x == 64 + 20 && y == 128 + 4) lit = 1'b1;
        if (lit) begin
            if (mode == 1) begin
                r = 8'hFF; g = 8'h7F; b = 8'h00;
            end else if ($urandom_range(0, 7) == 0) begin
                r = 8'h80; g = 8'h7F; b = 8'($urandom);
            end else begin
                r = 8'($urandom_range(128, 255)); g = 8'($urandom_range(0, 127)); b = 8'($urandom);
            end
        end else if (mode == 1) begin
            r = in_seg ? 8'h20 : 8'h00;
            g = r;
            b = r;
        end else begin
            case ($urandom_range(0, 3))
                0: begin r = 8'($urandom_range(0, 127)); g = 8'($urandom); end
                1: begin r = 8'($urandom); g = 8'($urandom_range(128, 255)); end
                2: begin r = 8'h7F; g = 8'h00; end
                default: begin r = 8'h80; g = 8'h80; end
            endcase
            b = 8'($urandom);
        end
        pix(1'b1, r, g, b);
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk50);
        for (int k = 0; k < 8; k++) check($sformatf("rst_hex%0d", k), 32'(get_hex(k)), 32'h0);
        check("rst_done", 32'(frame_done), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        reset_n = 1'b1;
        m_search = 1'b1;
        m_good = 0;
        for (int k = 0; k < 8; k++) exp_hex[k] = 8'h00;
    endtask

    task automatic render_frame(input int n_lines, input int short_y, input int mode, input int rst_y);
        int npx;
        for (int y = 0; y < n_lines; y++) begin
            if (y == rst_y) mid_reset();
            npx = (y == short_y) ? W - 1 : W;
            for (int x = 0; x < npx; x++) draw_px(x, y, mode, cur_glitch);
            pix(1'b0, 8'h00, 8'h00, 8'h00);
        end
    endtask

    // Ends the frame with a vs pulse and checks the outcome against the model.
    task automatic vsync(input bit ok);
        int d0;
        int e0;
        bit good;
        bit bad;
        logic [7:0] old0;
        d0 = cnt_done;
        e0 = cnt_err;
        good = !m_search && ok;
        bad = !m_search && !ok;
        old0 = exp_hex[0];
        if (good) begin
            for (int k = 0; k < 8; k++) exp_hex[k] = (64 * (k + 2) <= W) ? pat[k] : 8'h00;
            if (cur_glitch) begin
`ifdef VGA_LED_DECODER_MAJORITY_EN
                exp_hex[0][0] = 1'b0;
`else
                exp_hex[0][0] = 1'b1;
`endif
            end
            if (m_good < LOCK) m_good++;
        end else if (bad) begin
            m_good = 0;
        end
        m_search = 1'b0;

        vga_vs = 1'b0;
        @(negedge clk50);
        check("hex0_before_commit", 32'(hex0), 32'(old0));
        @(negedge clk50);
        for (int k = 0; k < 8; k++) exp_q.push_back(exp_hex[k]);
        for (int k = 0; k < 8; k++) check($sformatf("hex%0d", k), 32'(get_hex(k)), 32'(exp_q.pop_front()));
        repeat (2) @(negedge clk50);
        vga_vs = 1'b1;
        repeat (6) @(negedge clk50);
        check("done_pulses", 32'(cnt_done - d0), good ? 32'd1 : 32'd0);
        check("err_pulses", 32'(cnt_err - e0), bad ? 32'd1 : 32'd0);
        check("locked", 32'(locked), (m_good >= LOCK) ? 32'd1 : 32'd0);
    endtask

    task automatic random_pat();
        for (int k = 0; k < 8; k++) pat[k] = 8'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        vga_clk = 1'b0;
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        vga_blank_n = 1'b0;
        vga_r = 8'h00;
        vga_g = 8'h00;
        vga_b = 8'h00;
        for (int k = 0; k < 8; k++) exp_hex[k] = 8'h00;
        repeat (3) @(negedge clk50);
        for (int k = 0; k < 8; k++) check($sformatf("reset_hex%0d", k), 32'(get_hex(k)), 32'h0);
        check("reset_done", 32'(frame_done), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk50);

        // First vs fall only arms tracking.
        vsync(1'b1);

        // Clean digits, three frames; lock on the second.
        pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
        for (int i = 0; i < 3; i++) begin
            render_frame(H, -1, 1, -1);
            vsync(1'b1);
        end

        // All segments lit, random lit colours.
        for (int k = 0; k < 8; k++) pat[k] = 8'hFF;
        render_frame(H, -1, 0, -1);
        vsync(1'b1);

        // Dark gray segments on black, then FF/7F lit against gray.
        for (int k = 0; k < 8; k++) pat[k] = 8'h00;
        render_frame(H, -1, 1, -1);
        vsync(1'b1);
        random_pat();
        render_frame(H, -1, 1, -1);
        vsync(1'b1);

        // Random patterns with random colours near the threshold.
        for (int i = 0; i < 2; i++) begin
            random_pat();
            render_frame(H, -1, 0, -1);
            vsync(1'b1);
        end

        // Good 5B frame, truncated frame, then recovery.
        for (int k = 0; k < 8; k++) pat[k] = 8'h5B;
        render_frame(H, -1, 0, -1);
        vsync(1'b1);
        random_pat();
        render_frame(H - 1, -1, 0, -1);
        vsync(1'b0);
        random_pat();
        render_frame(H, -1, 0, -1);
        vsync(1'b1);

        // One short line, then recovery.
        random_pat();
        render_frame(H, $urandom_range(0, H - 1), 0, -1);
        vsync(1'b0);
        random_pat();
        render_frame(H, -1, 0, -1);
        vsync(1'b1);

        // Reset at line 200; next vs only re-arms; following frame commits.
        random_pat();
        render_frame(H, -1, 0, 200);
        vsync(1'b1);
        random_pat();
        render_frame(H, -1, 0, -1);
        vsync(1'b1);

        // Segment a of digit 0 off with a single lit centre pixel.
        random_pat();
        pat[0][0] = 1'b0;
        cur_glitch = 1'b1;
        render_frame(H, -1, 1, -1);
        vsync(1'b1);
        cur_glitch = 1'b0;

        check("done_err_overlap", 32'(cnt_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
